// File: rtl/multicycle_ctrl.sv
// Multi-cycle sequencer for the RV32I core: FETCH/DECODE/EXEC/MEM/WB with
// memory handshakes, timeout detection and a sticky HALT state.
module multicycle_ctrl #(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        is_lui,
    input  logic        is_auipc,
    input  logic        is_alu_reg,
    input  logic        is_alu_imm,
    input  logic        is_load,
    input  logic        is_store,
    input  logic        is_branch,
    input  logic        is_jal,
    input  logic        is_jalr,
    input  logic        is_system,
    input  logic        branch_taken,
    input  logic        imem_ready,
    input  logic        dmem_ready,
    output logic        imem_req,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic        ir_we,
    output logic        pc_we,
    output logic [1:0]  pc_sel,
    output logic        rf_we,
    output logic [2:0]  state,
    output logic        halted,
    output logic        illegal,
    output logic        bus_err,
    output logic [31:0] instret
);

    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_MEM    = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;
    localparam logic [2:0] S_HALT   = 3'd5;

    localparam logic        TMO_EN   = (MEM_TIMEOUT > 32'sd0) ? 1'b1 : 1'b0;
    localparam logic [31:0] TMO_LAST = (MEM_TIMEOUT > 32'sd0) ? 32'(MEM_TIMEOUT - 1) : 32'd0;

    logic [2:0]  state_r;
    logic [2:0]  next_state_s;
    logic [31:0] tmo_cnt_r;
    logic [31:0] instret_r;
    logic        illegal_r;
    logic        bus_err_r;
    logic        halted_r;
    logic        set_illegal_s;
    logic        set_bus_err_s;
    logic        tmo_hit_s;
    logic        class_any_s;

    function automatic logic any_flag(input logic [9:0] flags);
        return |flags;
    endfunction

    // Timeout fires on the last allowed wait cycle so HALT lands on the following edge.
    assign tmo_hit_s   = TMO_EN & (tmo_cnt_r == TMO_LAST);
    assign class_any_s = any_flag({is_lui, is_auipc, is_alu_reg, is_alu_imm, is_load,
                                   is_store, is_branch, is_jal, is_jalr, is_system});

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= S_FETCH;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state and error-flag decisions
    always_comb begin
        next_state_s  = state_r;
        set_illegal_s = 1'b0;
        set_bus_err_s = 1'b0;
        case (state_r)
            S_FETCH: begin
                if (imem_ready) begin
                    next_state_s = S_DECODE;
                end else if (tmo_hit_s) begin
                    next_state_s  = S_HALT;
                    set_bus_err_s = 1'b1;
                end else begin
                    next_state_s = S_FETCH;
                end
            end
            S_DECODE: begin
                if (is_system) begin
                    next_state_s = S_HALT;
                end else if (!class_any_s) begin
                    next_state_s  = S_HALT;
                    set_illegal_s = 1'b1;
                end else begin
                    next_state_s = S_EXEC;
                end
            end
            S_EXEC: begin
                if (is_branch) begin
                    next_state_s = S_FETCH;
                end else if (is_load || is_store) begin
                    next_state_s = S_MEM;
                end else begin
                    next_state_s = S_WB;
                end
            end
            S_MEM: begin
                if (dmem_ready) begin
                    if (is_load) begin
                        next_state_s = S_WB;
                    end else begin
                        next_state_s = S_FETCH;
                    end
                end else if (tmo_hit_s) begin
                    next_state_s  = S_HALT;
                    set_bus_err_s = 1'b1;
                end else begin
                    next_state_s = S_MEM;
                end
            end
            S_WB:    next_state_s = S_FETCH;
            S_HALT:  next_state_s = S_HALT;
            default: next_state_s = S_HALT;
        endcase
    end

    // Strobes and requests decoded from the registered state
    always_comb begin
        imem_req = 1'b0;
        dmem_req = 1'b0;
        dmem_we  = 1'b0;
        ir_we    = 1'b0;
        pc_we    = 1'b0;
        pc_sel   = 2'd0;
        rf_we    = 1'b0;
        case (state_r)
            S_FETCH: begin
                imem_req = 1'b1;
                ir_we    = imem_ready;
            end
            S_EXEC: begin
                if (is_branch) begin
                    pc_we = 1'b1;
                    if (branch_taken) begin
                        pc_sel = 2'd1;
                    end else begin
                        pc_sel = 2'd0;
                    end
                end else begin
                    pc_we = 1'b0;
                end
            end
            S_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = is_store;
                if (dmem_ready && !is_load) begin
                    pc_we = 1'b1;
                end else begin
                    pc_we = 1'b0;
                end
            end
            S_WB: begin
                rf_we = 1'b1;
                pc_we = 1'b1;
                if (is_jal) begin
                    pc_sel = 2'd1;
                end else if (is_jalr) begin
                    pc_sel = 2'd2;
                end else begin
                    pc_sel = 2'd0;
                end
            end
            default: begin
                pc_we = 1'b0;
            end
        endcase
    end

    // Wait-cycle counter, restarted whenever FETCH or MEM is entered
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tmo_cnt_r <= 32'd0;
        end else if ((next_state_s != state_r) &&
                     ((next_state_s == S_FETCH) || (next_state_s == S_MEM))) begin
            tmo_cnt_r <= 32'd0;
        end else if (((state_r == S_FETCH) && !imem_ready) ||
                     ((state_r == S_MEM) && !dmem_ready)) begin
            tmo_cnt_r <= tmo_cnt_r + 32'd1;
        end else begin
            tmo_cnt_r <= tmo_cnt_r;
        end
    end

    // Sticky status flags and retired-instruction counter
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            illegal_r <= 1'b0;
            bus_err_r <= 1'b0;
            halted_r  <= 1'b0;
            instret_r <= 32'd0;
        end else begin
            illegal_r <= illegal_r | set_illegal_s;
            bus_err_r <= bus_err_r | set_bus_err_s;
            halted_r  <= halted_r | (next_state_s == S_HALT);
            if (pc_we) begin
                instret_r <= instret_r + 32'd1;
            end else begin
                instret_r <= instret_r;
            end
        end
    end

    assign state   = state_r;
    assign halted  = halted_r;
    assign illegal = illegal_r;
    assign bus_err = bus_err_r;
    assign instret = instret_r;

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Multi-cycle sequencer for the RV32I core. It steps each instruction through FETCH, DECODE, EXEC, MEM and WB, using the class flags from `decoder_glue`. It drives the instruction-register, PC and register-file write strobes, and handshakes with the instruction and data memories. It also detects illegal opcodes, SYSTEM instructions and memory timeouts, and parks the core in HALT when any of them occurs.

## Interface
- `MEM_TIMEOUT`, default 16: maximum cycles to wait for a memory ready; 0 disables the timeout.
- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `is_lui, is_auipc, is_alu_reg, is_alu_imm, is_load, is_store, is_branch, is_jal, is_jalr, is_system`  in  1 each  decoder class flags, valid from DECODE onward.
- `branch_taken`  in  1  branch comparator result, sampled in EXEC.
- `imem_ready`  in  1  instruction memory data valid.
- `dmem_ready`  in  1  data memory access complete.
- `imem_req`  out  1  instruction fetch request.
- `dmem_req`  out  1  data access request.
- `dmem_we`  out  1  data write qualifier.
- `ir_we`  out  1  latch fetched instruction.
- `pc_we`  out  1  update PC (one per retired instruction).
- `pc_sel`  out  2  next-PC select: 0 = PC+4, 1 = PC+imm, 2 = (rs1+imm)&~1.
- `rf_we`  out  1  register-file write strobe.
- `state`  out  3  current state: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5.
- `halted`  out  1  core stopped.
- `illegal`  out  1  sticky illegal-opcode flag.
- `bus_err`  out  1  sticky memory-timeout flag.
- `instret`  out  32  retired-instruction count.

## Operation
- Reset (`rst_n`=0 at a clock edge) forces the following on the next cycle:
  - `state`=FETCH.
  - `instret`=0.
  - `illegal`, `bus_err` and `halted` all 0.
  - All strobes low.
- The reset is obeyed mid-operation, including in MEM and HALT.
- **FETCH**: `imem_req`=1 (decoded from state).
  - On `imem_ready`=1: `ir_we`=1 that cycle, then go to DECODE.
- **DECODE**: one cycle.
  - No class flag set: `illegal`<=1, go to HALT.
  - `is_system`=1: go to HALT with no error flag.
  - Otherwise go to EXEC.
- **EXEC**: one cycle.
  - Branch: `pc_we`=1, `pc_sel` = `branch_taken` ? 1 : 0, then go to FETCH.
  - Load or store: go to MEM.
  - All other classes: go to WB.
- **MEM**: `dmem_req`=1, and `dmem_we`=`is_store`.
  - On `dmem_ready`, a load goes to WB.
  - On `dmem_ready`, a store asserts `pc_we`=1 with `pc_sel`=0, then goes to FETCH.
- **WB**: `rf_we`=1, `pc_we`=1, then go to FETCH.
  - `pc_sel`=1 for JAL, 2 for JALR, 0 for everything else.
- **HALT**: all strobes and requests are 0, `halted`=1. Only reset exits HALT.
- **Timeout counter**:
  - Clears on every entry to FETCH or MEM.
  - Increments each cycle in FETCH or MEM while the relevant ready is low.
  - When it reaches `MEM_TIMEOUT` with ready still low: `bus_err`<=1, go to HALT.
  - If ready and the timeout occur in the same cycle, ready wins.
- **`instret`**: +1 on every cycle with `pc_we`=1, modulo 2^32 (0xFFFFFFFF wraps to 0).
- **Ignored inputs**: ready inputs outside the matching request state, and `branch_taken` outside EXEC.

## Timing
- Every strobe (`ir_we`, `pc_we`, `rf_we`) is a single-cycle pulse, asserted combinationally from the registered state.
- `imem_req` and `dmem_req` stay high from state entry until the cycle in which ready is sampled high, and are low the next cycle.
- Latency with zero wait states (ready high on the first request cycle):
  - Branch: 3 cycles.
  - Store: 4 cycles.
  - ALU, LUI, AUIPC, JAL, JALR: 4 cycles.
  - Load: 5 cycles.
- Each wait cycle on imem or dmem adds exactly one cycle.
- Timeout halt: HALT is entered on the edge after `MEM_TIMEOUT` consecutive not-ready cycles.
- `halted`, `illegal` and `bus_err` are registered: visible the cycle after the decision, and sticky until reset.

## Test plan
- **ADDI, zero wait**: states 0,1,2,4,0 on consecutive cycles; `rf_we` and `pc_we` pulse in cycle 4 with `pc_sel`=0; `instret` 0 -> 1.
- **LW with dmem_ready delayed 3 cycles**: MEM lasts 4 cycles with `dmem_req` high throughout and `dmem_we`=0; total 8 cycles; `rf_we` pulses once in WB.
- **BEQ with branch_taken=1, then BEQ with branch_taken=0**: each takes 3 cycles; `pc_we` pulses in EXEC with `pc_sel`=1 and then 0; `rf_we` never asserts.
- **JAL then JALR**: WB asserts `pc_sel`=1 and then 2, with `rf_we`=1 in both.
- **All flags zero in DECODE**: `illegal`=1 and `state`=5 next cycle; no further `imem_req`; `rst_n` pulse returns to FETCH with flags cleared.
- **MEM_TIMEOUT=16, imem_ready held low**: `bus_err`=1 and `halted`=1 after 16 wait cycles; a second run with ready rising on exactly the 16th cycle completes normally with `bus_err`=0.
